// File: rtl/cp0_exc_ctrl.sv
// Exception sequencer driving the CP0 command port for SYSCALL, ERET and external interrupts.
// Define CP0_EXC_INT_EN to build the interrupt edge-detect, pending and irq_id logic.
module cp0_exc_ctrl #(
  parameter logic [29:0] HANDLER_PC = 30'h0000_0010,
  parameter int unsigned INT_LINES  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           dec_cp0_op,
  input  logic                 syscall_req,
  input  logic                 eret_req,
  input  logic [29:0]          req_pc,
  input  logic [INT_LINES-1:0] int_in,
  input  logic                 status_ie,
  input  logic [31:0]          cp0_epc,
  output logic [2:0]           cp0_op,
  output logic [29:0]          cp0_pc,
  output logic                 ack,
  output logic                 stall,
  output logic                 redirect_valid,
  output logic [29:0]          redirect_pc,
  output logic [2:0]           irq_id,
  output logic                 in_handler
);

  localparam logic [2:0] OpSave = 3'b011;
  localparam logic [2:0] OpEret = 3'b100;

  typedef enum logic [2:0] {StIdle, StSave, StVector, StEretRd, StEretJmp} state_e;

  state_e      state_q, state_d;
  logic [29:0] saved_pc_q, saved_pc_d;
  logic        in_handler_q, in_handler_d;
  logic        idle, take_eret, take_sys, take_irq, irq_ready, irq_seq;

  assign idle      = (state_q == StIdle);
  assign take_eret = idle & eret_req;
  assign take_sys  = idle & ~eret_req & syscall_req;
  assign take_irq  = idle & ~eret_req & ~syscall_req & irq_ready;

`ifdef CP0_EXC_INT_EN
  logic [INT_LINES-1:0] int_prev_q, pend_q, pend_d, pend_clr;
  logic [2:0]           low_idx, irq_sel_q, irq_id_q;
  logic                 irq_seq_q, irq_done;
  logic                 unused_epc;

  assign irq_ready = (|pend_q) & status_ie & ~in_handler_q;
  assign irq_done  = (state_q == StSave) & irq_seq_q;
  assign irq_seq   = irq_seq_q;
  assign irq_id    = irq_id_q;
  assign unused_epc = ^cp0_epc[1:0];

  // Lowest pending index wins.
  always_comb begin
    low_idx = '0;
    for (int i = int'(INT_LINES) - 1; i >= 0; i--) begin
      if (pend_q[i]) low_idx = 3'(i);
    end
  end

  // A fresh edge on the line being cleared keeps its bit set.
  always_comb begin
    pend_clr = '0;
    for (int i = 0; i < int'(INT_LINES); i++) begin
      pend_clr[i] = irq_done & (irq_sel_q == 3'(i));
    end
    pend_d = (pend_q & ~pend_clr) | (int_in & ~int_prev_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_prev_q <= '0;
      pend_q     <= '0;
      irq_sel_q  <= '0;
      irq_id_q   <= '0;
      irq_seq_q  <= 1'b0;
    end else begin
      int_prev_q <= int_in;
      pend_q     <= pend_d;
      if (idle) begin
        irq_seq_q <= take_irq;
        irq_sel_q <= low_idx;
      end
      if (irq_done) irq_id_q <= irq_sel_q;
    end
  end
`else
  logic unused_in;

  assign irq_ready = 1'b0;
  assign irq_seq   = 1'b0;
  assign irq_id    = 3'b000;
  assign unused_in = ^{int_in, status_ie, cp0_epc[1:0]};
`endif

  always_comb begin
    state_d        = state_q;
    saved_pc_d     = saved_pc_q;
    in_handler_d   = in_handler_q;
    cp0_op         = 3'b000;
    cp0_pc         = '0;
    ack            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (state_q)
      StIdle: begin
        cp0_op = dec_cp0_op;
        if (take_eret) begin
          state_d = StEretRd;
        end else if (take_sys || take_irq) begin
          state_d = StSave;
        end
        if (take_eret || take_sys || take_irq) saved_pc_d = req_pc;
      end
      StSave: begin
        cp0_op       = OpSave;
        cp0_pc       = saved_pc_q;
        ack          = ~irq_seq;
        in_handler_d = 1'b1;
        state_d      = StVector;
      end
      StVector: begin
        redirect_valid = 1'b1;
        redirect_pc    = HANDLER_PC;
        state_d        = StIdle;
      end
      StEretRd: begin
        cp0_op     = OpEret;
        ack        = 1'b1;
        saved_pc_d = cp0_epc[31:2];
        state_d    = StEretJmp;
      end
      StEretJmp: begin
        redirect_valid = 1'b1;
        redirect_pc    = saved_pc_q;
        in_handler_d   = 1'b0;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign stall      = ~idle | take_eret | take_sys | take_irq;
  assign in_handler = in_handler_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      saved_pc_q   <= '0;
      in_handler_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      saved_pc_q   <= saved_pc_d;
      in_handler_q <= in_handler_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: a plan-queue model checked every negedge plus directed literal checks.
module tb_cp0_exc_ctrl;

  localparam int unsigned NL  = 4;
  localparam logic [29:0] HPC = 30'h0000_0010;
`ifdef CP0_EXC_INT_EN
  localparam bit IntEn = 1'b1;
`else
  localparam bit IntEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    dec_cp0_op;
  logic          syscall_req, eret_req, status_ie;
  logic [29:0]   req_pc;
  logic [NL-1:0] int_in;
  logic [31:0]   cp0_epc;
  logic [2:0]    cp0_op, irq_id;
  logic [29:0]   cp0_pc, redirect_pc;
  logic          ack, stall, redirect_valid, in_handler;

  always #5 clk = ~clk;

  cp0_exc_ctrl #(.HANDLER_PC(HPC), .INT_LINES(NL)) dut (
    .clk(clk), .rst_n(rst_n), .dec_cp0_op(dec_cp0_op), .syscall_req(syscall_req),
    .eret_req(eret_req), .req_pc(req_pc), .int_in(int_in), .status_ie(status_ie),
    .cp0_epc(cp0_epc), .cp0_op(cp0_op), .cp0_pc(cp0_pc), .ack(ack), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .irq_id(irq_id),
    .in_handler(in_handler)
  );

  int unsigned checks = 0;
  int unsigned passes = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Model: a taken request expands into a two-step plan of expected outputs and side effects.
  typedef struct {
    logic [2:0]  op;
    logic [29:0] pc;
    logic        ack;
    logic        rv;
    logic [29:0] rpc;
    logic        set_ih;
    logic        clr_ih;
    int          line;
    logic        cap_epc;
    logic        use_epc;
  } step_t;

  function automatic step_t mk(logic [2:0] op, logic [29:0] pc, logic a, logic rv,
                               logic [29:0] rpc, logic s, logic c, int line, logic cap,
                               logic use_e);
    step_t st;
    st.op = op; st.pc = pc; st.ack = a; st.rv = rv; st.rpc = rpc; st.set_ih = s;
    st.clr_ih = c; st.line = line; st.cap_epc = cap; st.use_epc = use_e;
    return st;
  endfunction

  function automatic int lowest(logic [NL-1:0] v);
    for (int i = 0; i < int'(NL); i++) if (v[i]) return i;
    return -1;
  endfunction

  step_t         plan[$];
  step_t         cur;
  logic          m_ih;
  logic [29:0]   m_epc;
  logic [NL-1:0] m_pend, m_prev, m_clr;
  logic [2:0]    m_id;
  logic [2:0]    e_op;
  logic [29:0]   e_pc, e_rpc;
  logic          e_ack, e_rv, e_stall, irq_ok;

  always @(negedge clk) begin
    if (!rst_n) begin
      plan.delete();
      m_ih = 1'b0; m_pend = '0; m_prev = '0; m_id = '0; m_epc = '0;
    end
    cur = mk(3'b000, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    e_op = dec_cp0_op; e_pc = '0; e_ack = 1'b0; e_rv = 1'b0; e_rpc = '0; e_stall = 1'b0;
    if (plan.size() != 0) begin
      cur = plan.pop_front();
      e_op = cur.op; e_pc = cur.pc; e_ack = cur.ack; e_rv = cur.rv;
      e_rpc = cur.use_epc ? m_epc : cur.rpc;
      e_stall = 1'b1;
    end else begin
      irq_ok = IntEn && (m_pend != '0) && status_ie && !m_ih;
      if (eret_req || syscall_req || irq_ok) begin
        e_stall = 1'b1;
        if (rst_n) begin
          if (eret_req) begin
            plan.push_back(mk(3'b100, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, -1, 1'b1, 1'b0));
            plan.push_back(mk(3'b000, '0, 1'b0, 1'b1, '0, 1'b0, 1'b1, -1, 1'b0, 1'b1));
          end else begin
            plan.push_back(mk(3'b011, req_pc, syscall_req, 1'b0, '0, 1'b1, 1'b0,
                              syscall_req ? -1 : lowest(m_pend), 1'b0, 1'b0));
            plan.push_back(mk(3'b000, '0, 1'b0, 1'b1, HPC, 1'b0, 1'b0, -1, 1'b0, 1'b0));
          end
        end
      end
    end
    chk("cyc_cp0_op", cp0_op, e_op);
    chk("cyc_cp0_pc", cp0_pc, e_pc);
    chk("cyc_ack", ack, e_ack);
    chk("cyc_stall", stall, e_stall);
    chk("cyc_redirect_valid", redirect_valid, e_rv);
    chk("cyc_redirect_pc", redirect_pc, e_rpc);
    chk("cyc_irq_id", irq_id, m_id);
    chk("cyc_in_handler", in_handler, m_ih);
    if (rst_n) begin
      if (cur.cap_epc) m_epc = cp0_epc[31:2];
      if (cur.set_ih) m_ih = 1'b1;
      if (cur.clr_ih) m_ih = 1'b0;
      m_clr = '0;
      if (cur.line >= 0) begin
        m_clr[cur.line] = 1'b1;
        m_id = 3'(cur.line);
      end
      m_pend = (m_pend & ~m_clr) | (IntEn ? (int_in & ~m_prev) : '0);
      m_prev = int_in;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_eret(input logic [31:0] epc);
    cp0_epc = epc; eret_req = 1'b1;
    tick(); tick(); eret_req = 1'b0; tick();
  endtask

  initial begin
    rst_n = 1'b0; dec_cp0_op = 3'b000; syscall_req = 1'b0; eret_req = 1'b0;
    req_pc = '0; int_in = '0; status_ie = 1'b0; cp0_epc = '0;
    @(negedge clk);
    chk("rst_cp0_op", cp0_op, 3'b000);
    chk("rst_stall", stall, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_in_handler", in_handler, 0);
    chk("rst_irq_id", irq_id, 0);
    tick(); rst_n = 1'b1;

    dec_cp0_op = 3'b001;
    @(negedge clk); chk("fwd_mfc0", cp0_op, 3'b001);
    tick(); dec_cp0_op = 3'b000;

    // SYSCALL
    syscall_req = 1'b1; req_pc = 30'h100;
    @(negedge clk); chk("sys_stall_n", stall, 1);
    tick();
    @(negedge clk);
    chk("sys_op", cp0_op, 3'b011); chk("sys_pc", cp0_pc, 30'h100); chk("sys_ack", ack, 1);
    chk("sys_stall_n1", stall, 1);
    tick(); syscall_req = 1'b0;
    @(negedge clk);
    chk("sys_rv", redirect_valid, 1); chk("sys_rpc", redirect_pc, 30'h10);
    chk("sys_stall_n2", stall, 1); chk("sys_ih", in_handler, 1);
    tick();
    @(negedge clk); chk("sys_done_stall", stall, 0);

    // ERET
    cp0_epc = 32'h400; eret_req = 1'b1;
    tick();
    @(negedge clk); chk("eret_op", cp0_op, 3'b100); chk("eret_ack", ack, 1);
    tick(); eret_req = 1'b0;
    @(negedge clk);
    chk("eret_rv", redirect_valid, 1); chk("eret_rpc", redirect_pc, 30'h100);
    chk("eret_ih_before", in_handler, 1);
    tick();
    @(negedge clk); chk("eret_ih_after", in_handler, 0);

    // Simultaneous ERET and SYSCALL; decode op ignored while busy
    dec_cp0_op = 3'b010; eret_req = 1'b1; syscall_req = 1'b1; req_pc = 30'h2a0;
    cp0_epc = 32'h0000_0abc;
    tick();
    @(negedge clk); chk("both_eret_op", cp0_op, 3'b100); chk("both_eret_ack", ack, 1);
    tick(); eret_req = 1'b0;
    tick(); tick();
    @(negedge clk); chk("both_sys_op", cp0_op, 3'b011); chk("both_sys_pc", cp0_pc, 30'h2a0);
    tick(); syscall_req = 1'b0; dec_cp0_op = 3'b000;
    tick();
    do_eret(32'h1000);

`ifdef CP0_EXC_INT_EN
    // Two edges at once: line 1 first, line 2 waits until after ERET
    status_ie = 1'b1; int_in = 4'b0110; req_pc = 30'h200;
    tick();
    @(negedge clk); chk("irq_take_stall", stall, 1);
    tick();
    @(negedge clk);
    chk("irq_save_op", cp0_op, 3'b011); chk("irq_save_ack", ack, 0);
    chk("irq_save_pc", cp0_pc, 30'h200);
    tick();
    @(negedge clk); chk("irq_vec_rv", redirect_valid, 1); chk("irq_id_1", irq_id, 1);
    tick(); tick();
    @(negedge clk); chk("irq2_blocked", stall, 0);
    cp0_epc = 32'h800; eret_req = 1'b1;
    tick(); eret_req = 1'b0;
    tick();
    @(negedge clk); chk("irq_eret_rpc", redirect_pc, 30'h200);
    tick();
    @(negedge clk); chk("irq2_take", stall, 1);
    tick(); tick();
    @(negedge clk); chk("irq_id_2", irq_id, 2);
    tick(); int_in = '0;
    do_eret(32'h900);

    // Masked edge stays pending until enabled
    status_ie = 1'b0; int_in = 4'b0001;
    tick(); int_in = '0;
    tick(); tick();
    @(negedge clk); chk("mask_no_stall", stall, 0);
    status_ie = 1'b1;
    #1; chk("unmask_take", stall, 1);
    tick();
    @(negedge clk); chk("unmask_save_op", cp0_op, 3'b011); chk("unmask_ack", ack, 0);
    tick(); tick();
    @(negedge clk); chk("irq_id_0", irq_id, 0);
    do_eret(32'h40);
`else
    status_ie = 1'b1; int_in = 4'b1111;
    tick();
    @(negedge clk); chk("noint_stall_a", stall, 0);
    tick();
    @(negedge clk); chk("noint_stall_b", stall, 0); chk("noint_irq_id", irq_id, 0);
    int_in = '0;
    tick();
`endif

    // Reset asserted during VECTOR
    syscall_req = 1'b1; req_pc = 30'h55;
    tick(); syscall_req = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("rstv_rv", redirect_valid, 0); chk("rstv_rpc", redirect_pc, 0);
    chk("rstv_stall", stall, 0); chk("rstv_ih", in_handler, 0);
    chk("rstv_op", cp0_op, 0); chk("rstv_irq_id", irq_id, 0);
    tick(); tick(); rst_n = 1'b1;
    @(negedge clk); chk("rstv_no_redirect_a", redirect_valid, 0);
    tick();
    @(negedge clk); chk("rstv_no_redirect_b", redirect_valid, 0); chk("rstv_idle", stall, 0);
    tick(); tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
